// File: rtl/structure1_pkg.sv
// Types and constants shared by the structure 1 FC1 datapath blocks.
package structure1_pkg;

  localparam int FC1_NUM_NEURONS = 128;
  localparam int FC1_BIAS_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/structure1_sync_fifo.sv
// Small first-word-fall-through synchronous FIFO with full/empty/count status.
module structure1_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/structure1_fc1_bias_sched.sv
// FC1 bias ROM sequencer: credit-limited reads, latency tracking, valid/ready output.
// Optional `STRUCTURE1_FC1_BIAS_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module structure1_fc1_bias_sched
  import structure1_pkg::*;
#(
  parameter int NUM_NEURONS = FC1_NUM_NEURONS,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = FC1_BIAS_W,
  parameter int ROM_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              bias_valid,
  input  logic              bias_ready,
  output logic [DATA_W-1:0] bias_data,
  output logic [ADDR_W-1:0] bias_idx
`ifdef STRUCTURE1_FC1_BIAS_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int FIFO_DEPTH = ROM_LAT + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

  sched_state_t      r_state;
  logic [ADDR_W-1:0] r_issue_cnt;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic              r_done;
  logic [ROM_LAT-1:0] r_vld;
  logic [ROM_LAT-1:0] w_vld_next;

  logic [3:0]        w_inflight;
  logic [3:0]        w_used;
  logic              w_start;
  logic              w_issue;
  logic              w_pop;
  logic              w_last_pop;
  logic              w_fifo_wr;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [DATA_W-1:0] w_fifo_head;

  assign w_start    = (r_state == ST_IDLE) && start;
  assign w_pop      = !w_fifo_empty && bias_ready;
  assign w_last_pop = w_pop && (r_state == ST_DRAIN) && (r_idx == LAST_ADDR);
  assign w_fifo_wr  = r_vld[ROM_LAT-1];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) w_inflight = w_inflight + 4'(r_vld[i]);
  end

  // A word leaving the FIFO this cycle frees its credit immediately, which
  // keeps the stream at one word per cycle when the consumer never stalls.
  assign w_used  = w_inflight + 4'(w_fifo_cnt) - 4'(w_pop);
  assign w_issue = (r_state == ST_FETCH) && (w_used < 4'(FIFO_DEPTH));

  assign w_vld_next[0] = w_issue;
  for (genvar gi = 1; gi < ROM_LAT; gi++) begin : g_lat
    assign w_vld_next[gi] = r_vld[gi-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_issue_cnt <= '0;
      r_addr_hold <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vld       <= '0;
    end else begin
      r_done <= 1'b0;
      r_vld  <= w_vld_next;
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
        r_addr_hold <= r_issue_cnt;
      end
      // The final index is held so a finished pass reports the last neuron.
      if (w_pop && !w_last_pop) r_idx <= r_idx + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_FETCH;
            r_busy      <= 1'b1;
            r_issue_cnt <= '0;
            r_idx       <= '0;
          end
        end
        ST_FETCH: begin
          if (w_issue && (r_issue_cnt == LAST_ADDR)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_last_pop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  structure1_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (rom_dout),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_cnt)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_fifo_wr && w_fifo_full));

  assign busy       = r_busy;
  assign done       = r_done;
  assign rom_en     = w_issue;
  assign rom_addr   = w_issue ? r_issue_cnt : r_addr_hold;
  assign bias_valid = !w_fifo_empty;
  assign bias_data  = w_fifo_empty ? '0 : w_fifo_head;
  assign bias_idx   = r_idx;

`ifdef STRUCTURE1_FC1_BIAS_SCHED_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_stall_cnt <= '0;
    end else if (bias_valid && !bias_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  // Stall instrumentation is not built in this configuration.
`endif

endmodule

// File: tb/tb_structure1_fc1_bias_sched.sv
// Scoreboard bench: three scheduler configurations run concurrently on one clock.
`timescale 1ns/1ps
module tb_structure1_fc1_bias_sched;

  localparam int NCFG = 3;
  localparam int N_TAB   [NCFG] = '{4, 128, 256};
  localparam int LAT_TAB [NCFG] = '{1, 2, 1};
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit fin [NCFG];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int N   = N_TAB[gi];
    localparam int LAT = LAT_TAB[gi];

    logic          rst, start, bias_ready;
    logic          busy, done, rom_en, bias_valid;
    logic [AW-1:0] rom_addr, bias_idx;
    logic [DW-1:0] rom_dout, bias_data;
    logic [DW-1:0] rom_d1, rom_d2;
    logic [DW-1:0] rom_mem [256];
`ifdef STRUCTURE1_FC1_BIAS_SCHED_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    structure1_fc1_bias_sched #(
      .NUM_NEURONS (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .ROM_LAT     (LAT)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_dout   (rom_dout),
      .bias_valid (bias_valid),
      .bias_ready (bias_ready),
      .bias_data  (bias_data),
      .bias_idx   (bias_idx)
`ifdef STRUCTURE1_FC1_BIAS_SCHED_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
    );

    // ROM model: registered read, optional output register for latency 2.
    always @(posedge clk) begin
      if (rom_en) rom_d1 <= rom_mem[rom_addr];
      rom_d2 <= rom_d1;
    end
    assign rom_dout = (LAT == 1) ? rom_d1 : rom_d2;

    logic [15:0]   exp_q [$];
    logic [15:0]   sb_e;
    int            cyc = 0;
    int            hs_cnt, done_cnt, en_cnt, stall_seen, max_out;
    int            start_cyc, first_en_cyc, first_vld_cyc, last_hs_cyc, done_cyc;
    logic [AW-1:0] last_addr = '0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;

    function automatic string nm(input string s);
      return $sformatf("cfg%0d_%s", gi, s);
    endfunction

    task automatic clr_stats();
      hs_cnt = 0; done_cnt = 0; en_cnt = 0; stall_seen = 0; max_out = 0;
      start_cyc = -1; first_en_cyc = -1; first_vld_cyc = -1;
      last_hs_cyc = -1; done_cyc = -1;
    endtask

    task automatic check_reset_vals();
      check(nm("rst_busy"), busy, 0);
      check(nm("rst_done"), done, 0);
      check(nm("rst_rom_en"), rom_en, 0);
      check(nm("rst_rom_addr"), rom_addr, 0);
      check(nm("rst_bias_valid"), bias_valid, 0);
      check(nm("rst_bias_data"), bias_data, 0);
      check(nm("rst_bias_idx"), bias_idx, 0);
    endtask

    // 0: always ready, 1: pattern 1,0,0,1, 2: random, 3: refuse the first 10 offers
    function automatic logic pick_ready(input int mode, input int k);
      case (mode)
        0:       return 1'b1;
        1:       return (k % 4 == 0) || (k % 4 == 3);
        2:       return ($urandom_range(2) != 0);
        default: return (stall_seen >= 10);
      endcase
    endfunction

    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        last_addr  = '0;
        prev_stall = 1'b0;
      end else begin
        if (start && !busy && start_cyc < 0) start_cyc = cyc;
        if (rom_en) begin
          check(nm("rom_addr_seq"), rom_addr, en_cnt % (1 << AW));
          check(nm("rom_en_busy"), busy, 1);
          if (first_en_cyc < 0) first_en_cyc = cyc;
          en_cnt++;
          last_addr = rom_addr;
        end else begin
          check(nm("rom_addr_hold"), rom_addr, last_addr);
        end
        if (prev_stall) begin
          check(nm("hold_valid"), bias_valid, 1);
          check(nm("hold_data"), bias_data, prev_data);
          check(nm("hold_idx"), bias_idx, prev_idx);
        end
        if (bias_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (bias_valid && bias_ready) begin
          check(nm("word_expected"), exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            check(nm("bias_idx"), bias_idx, sb_e[15:8]);
            check(nm("bias_data"), bias_data, sb_e[7:0]);
          end
          hs_cnt++;
          last_hs_cyc = cyc;
        end
        prev_stall = bias_valid && !bias_ready;
        prev_data  = bias_data;
        prev_idx   = bias_idx;
        if (prev_stall) stall_seen++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check(nm("busy_at_done"), busy, 0);
        end
        if (en_cnt - hs_cnt > max_out) max_out = en_cnt - hs_cnt;
      end
    end

    task automatic do_pass(input int mode, input bit repulse, input int rst_after);
      int  k;
      bit  repulsed;
      repulsed = 1'b0;
      clr_stats();
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back({8'(i), rom_mem[i]});
      @(posedge clk); #1;
      start      = 1'b1;
      bias_ready = pick_ready(mode, 0);
      for (k = 1; k < 8 * N + 100 && done_cnt == 0; k++) begin
        @(posedge clk); #1;
        start      = 1'b0;
        bias_ready = pick_ready(mode, k);
        if (repulse && !repulsed && busy && hs_cnt >= N / 2) begin
          start    = 1'b1;
          repulsed = 1'b1;
        end
        if (rst_after >= 0 && hs_cnt >= rst_after) begin
          rst   = 1'b1;
          start = 1'b0;
          @(posedge clk);
          @(negedge clk);
          check_reset_vals();
          @(posedge clk); #1;
          rst = 1'b0;
          exp_q.delete();
          done_cnt = 0;
          repeat (4) @(negedge clk);
          check(nm("no_done_after_rst"), done_cnt, 0);
          return;
        end
      end
      check(nm("pass_finished"), done_cnt > 0, 1);
      repeat (4) @(negedge clk);
      check(nm("done_count"), done_cnt, 1);
      check(nm("words"), hs_cnt, N);
      check(nm("sb_empty"), exp_q.size(), 0);
      check(nm("rom_reads"), en_cnt, N);
      check(nm("last_addr"), last_addr, N - 1);
      check(nm("final_idx"), bias_idx, N - 1);
      check(nm("busy_end"), busy, 0);
      check(nm("outstanding_le_lat1"), max_out <= LAT + 1, 1);
      check(nm("done_lat"), done_cyc, last_hs_cyc + 1);
      check(nm("first_en_lat"), first_en_cyc, start_cyc + 1);
      check(nm("first_vld_lat"), first_vld_cyc, first_en_cyc + LAT + 1);
      if (mode == 0) check(nm("back_to_back"), last_hs_cyc - first_vld_cyc, N - 1);
`ifdef STRUCTURE1_FC1_BIAS_SCHED_STALL_CNT_EN
      check(nm("stall_cnt"), stall_cnt, stall_seen);
      if (mode == 3) check(nm("stall_cnt_10"), stall_cnt, 10);
`endif
    endtask

    initial begin
      rst        = 1'b1;
      start      = 1'b0;
      bias_ready = 1'b0;
      for (int a = 0; a < 256; a++)
        rom_mem[a] = (gi == 0) ? 8'(a + 16) : 8'($urandom);
      clr_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1;
      rst = 1'b0;
      do_pass((gi == 0) ? 0 : ((gi == 1) ? 1 : 2), 1'b1, -1);
      do_pass(2, 1'b0, (N > 8) ? 5 : 2);
      do_pass(2, 1'b0, -1);
      do_pass(3, 1'b0, -1);
      do_pass(0, 1'b0, -1);
      fin[gi] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(fin[0] && fin[1] && fin[2]) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("all_cfgs_finished", int'(fin[0]) + int'(fin[1]) + int'(fin[2]), NCFG);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
